// File: rtl/vme_bus_arbiter.sv
// ---------------------------------------------------------------------------
// vme_bus_arbiter
//
// VME system-controller (slot-1) bus arbiter for LEVELS request/grant levels.
// Level 0 has the highest priority. The arbiter offers the bus on one
// BGOUT daisy-chain head, watches BBSY to follow ownership, withdraws a grant
// that nobody takes up, and in fixed-priority mode asks the current owner to
// release the bus (BCLR) when a higher-priority level requests it.
//
// Parameters
//   LEVELS          number of request/grant levels (2..8)
//   ROUND_ROBIN     0: fixed priority with BCLR pre-emption
//                   1: round-robin rotation, BCLR never asserted
//   TIMEOUT_CYCLES  cycles a grant may stay untaken before withdrawal
//                   (0 disables the timeout)
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high reset
//   vme_br         bus requests, active-low, asynchronous
//   vme_bbsy       backplane BBSY, active-low, asynchronous
//   vme_bgout      registered bus grants, active-low, at most one bit low
//   vme_bclr       registered bus clear, active-low
//   grant_active   high while a grant is offered or the bus is owned
//   grant_level    level currently granted or owning the bus
//   timeout_pulse  one-cycle pulse when a grant is withdrawn by timeout
// ---------------------------------------------------------------------------
module vme_bus_arbiter #(
  parameter int unsigned LEVELS         = 4,
  parameter int unsigned ROUND_ROBIN    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LEVELS-1:0]         vme_br,
  input  logic                      vme_bbsy,
  output logic [LEVELS-1:0]         vme_bgout,
  output logic                      vme_bclr,
  output logic                      grant_active,
  output logic [$clog2(LEVELS)-1:0] grant_level,
  output logic                      timeout_pulse
);

  localparam int unsigned LW = $clog2(LEVELS);
  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LEVELS-1:0] br_m, br_s;
  logic              bbsy_m, bbsy_s;

  logic [TW-1:0]     cnt, cnt_nxt;
  logic [LW-1:0]     last, last_nxt;
  logic [LW-1:0]     level_nxt;
  logic [LW-1:0]     winner;
  logic              any_req;
  logic              preempt;
  logic              timeout_hit;

  logic [LEVELS-1:0] bgout_nxt;
  logic              bclr_nxt;
  logic              pulse_nxt;

  // -------------------------------------------------------------------------
  // Two-flop synchronisers; every decision below uses br_s / bbsy_s only.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      br_m   <= '1;
      br_s   <= '1;
      bbsy_m <= 1'b1;
      bbsy_s <= 1'b1;
    end else begin
      br_m   <= vme_br;
      br_s   <= br_m;
      bbsy_m <= vme_bbsy;
      bbsy_s <= bbsy_m;
    end
  end

  // -------------------------------------------------------------------------
  // Winner selection. Round-robin searches upward from the level after the
  // last one granted, wrapping at LEVELS.
  // -------------------------------------------------------------------------
  always_comb begin : pick
    int unsigned idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    if (ROUND_ROBIN != 0) begin
      for (int unsigned k = 1; k <= LEVELS; k++) begin
        idx = (32'(last) + k) % LEVELS;
        if (!any_req && !br_s[idx]) begin
          any_req = 1'b1;
          winner  = LW'(idx);
        end
      end
    end else begin
      for (int unsigned i = 0; i < LEVELS; i++) begin
        if (!any_req && !br_s[i]) begin
          any_req = 1'b1;
          winner  = LW'(i);
        end
      end
    end
  end

  // A strictly higher-priority request than the current owner.
  always_comb begin
    preempt = 1'b0;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      if ((LW'(i) < grant_level) && !br_s[i]) begin
        preempt = 1'b1;
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  // -------------------------------------------------------------------------
  // State, counter and grant bookkeeping register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= LW'(LEVELS - 1);
      grant_level   <= '0;
      vme_bgout     <= '1;
      vme_bclr      <= 1'b1;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      last          <= last_nxt;
      grant_level   <= level_nxt;
      vme_bgout     <= bgout_nxt;
      vme_bclr      <= bclr_nxt;
      timeout_pulse <= pulse_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. In GRANT, BBSY takes precedence over withdrawal, which
  // takes precedence over the timeout. BUSY always passes through IDLE before
  // a new grant.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    level_nxt = grant_level;
    case (state)
      IDLE: begin
        if (any_req && bbsy_s) begin
          state_nxt = GRANT;
          level_nxt = winner;
          last_nxt  = winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!bbsy_s) begin
          state_nxt = BUSY;
        end else if (br_s[grant_level]) begin
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BUSY: begin
        if (bbsy_s) begin
          state_nxt = IDLE;
        end else if ((ROUND_ROBIN == 0) && preempt) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        // Held until release even if the pre-empting request goes away.
        if (bbsy_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. Registered outputs are derived from the next state so that
  // a grant can only be low in GRANT and BCLR only in CLEAR.
  // -------------------------------------------------------------------------
  always_comb begin
    bgout_nxt = '1;
    if (state_nxt == GRANT) begin
      bgout_nxt[level_nxt] = 1'b0;
    end
    bclr_nxt  = (state_nxt != CLEAR);
    pulse_nxt = (state == GRANT) && bbsy_s && !br_s[grant_level] && timeout_hit;
  end

  assign grant_active = (state != IDLE);

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for vme_bus_arbiter. Three configurations share the same random
// request/BBSY stimulus:
//   u0: LEVELS=4, fixed priority, TIMEOUT_CYCLES=16
//   u1: LEVELS=4, round-robin,    TIMEOUT_CYCLES=16
//   u2: LEVELS=5, fixed priority, timeout disabled
// Each is compared every cycle against a reference model that tracks the
// offered grant, bus ownership and the clear request as plain flags.
// ---------------------------------------------------------------------------
module tb_vme_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] br;
  logic       bbsy;

  always #5 clock = ~clock;

  logic [3:0] bg0, bg1;
  logic [4:0] bg2;
  logic       clr0, clr1, clr2;
  logic       act0, act1, act2;
  logic [1:0] lvl0, lvl1;
  logic [2:0] lvl2;
  logic       to0, to1, to2;

  vme_bus_arbiter #(.LEVELS(4), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(16)) u0 (
    .clock(clock), .reset(reset), .vme_br(br[3:0]), .vme_bbsy(bbsy),
    .vme_bgout(bg0), .vme_bclr(clr0), .grant_active(act0),
    .grant_level(lvl0), .timeout_pulse(to0));

  vme_bus_arbiter #(.LEVELS(4), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(16)) u1 (
    .clock(clock), .reset(reset), .vme_br(br[3:0]), .vme_bbsy(bbsy),
    .vme_bgout(bg1), .vme_bclr(clr1), .grant_active(act1),
    .grant_level(lvl1), .timeout_pulse(to1));

  vme_bus_arbiter #(.LEVELS(5), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) u2 (
    .clock(clock), .reset(reset), .vme_br(br[4:0]), .vme_bbsy(bbsy),
    .vme_bgout(bg2), .vme_bclr(clr2), .grant_active(act2),
    .grant_level(lvl2), .timeout_pulse(to2));

  logic [7:0] o_bg  [3];
  logic       o_clr [3];
  logic       o_act [3];
  logic [7:0] o_lvl [3];
  logic       o_to  [3];

  assign o_bg[0]  = {4'h0, bg0};
  assign o_bg[1]  = {4'h0, bg1};
  assign o_bg[2]  = {3'h0, bg2};
  assign o_clr[0] = clr0;
  assign o_clr[1] = clr1;
  assign o_clr[2] = clr2;
  assign o_act[0] = act0;
  assign o_act[1] = act1;
  assign o_act[2] = act2;
  assign o_lvl[0] = {6'h0, lvl0};
  assign o_lvl[1] = {6'h0, lvl1};
  assign o_lvl[2] = {5'h0, lvl2};
  assign o_to[0]  = to0;
  assign o_to[1]  = to1;
  assign o_to[2]  = to2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int nlev [3] = '{4, 4, 5};
  bit rr   [3] = '{1'b0, 1'b1, 1'b0};
  int tmo  [3] = '{16, 16, 0};

  int offer [3];   // level currently offered a grant, -1 if none
  int owner [3];   // level last granted (reported as grant_level)
  int age   [3];   // cycles the current offer has been pending
  int last  [3];   // last level granted, for rotation
  bit own   [3];   // bus owned (BBSY seen after a grant)
  bit clr   [3];   // clear requested of the owner
  bit pulse [3];

  logic [7:0] sbr1, sbr2;   // request pins seen one / two edges ago
  logic       sbb1, sbb2;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      offer[i] = -1;
      owner[i] = 0;
      age[i]   = 0;
      last[i]  = nlev[i] - 1;
      own[i]   = 1'b0;
      clr[i]   = 1'b0;
      pulse[i] = 1'b0;
    end
    sbr1 = '1; sbr2 = '1; sbb1 = 1'b1; sbb2 = 1'b1;
  endtask

  function automatic int pick(int i, logic [7:0] req);
    int w;
    w = -1;
    if (rr[i]) begin
      for (int k = 1; k <= nlev[i]; k++)
        if (w < 0 && !req[(last[i] + k) % nlev[i]]) w = (last[i] + k) % nlev[i];
    end else begin
      for (int j = nlev[i] - 1; j >= 0; j--)
        if (!req[j]) w = j;
    end
    return w;
  endfunction

  task automatic model_arb(int i, logic [7:0] req, logic bb);
    bit higher;
    int w;
    pulse[i] = 1'b0;
    if (offer[i] >= 0) begin
      if (!bb) begin
        offer[i] = -1;
        own[i]   = 1'b1;
      end else if (req[owner[i]]) begin
        offer[i] = -1;
      end else if (tmo[i] != 0 && age[i] == tmo[i] - 1) begin
        offer[i] = -1;
        pulse[i] = 1'b1;
      end else begin
        age[i]++;
      end
    end else if (clr[i]) begin
      if (bb) begin
        clr[i] = 1'b0;
        own[i] = 1'b0;
      end
    end else if (own[i]) begin
      higher = 1'b0;
      for (int j = 0; j < owner[i]; j++) if (!req[j]) higher = 1'b1;
      if (bb) own[i] = 1'b0;
      else if (!rr[i] && higher) clr[i] = 1'b1;
    end else begin
      w = pick(i, req);
      if (w >= 0 && bb) begin
        offer[i] = w;
        owner[i] = w;
        age[i]   = 0;
        last[i]  = w;
      end
    end
  endtask

  task automatic model_step(input logic [7:0] pin_br, input logic pin_bb);
    for (int i = 0; i < 3; i++) model_arb(i, sbr2, sbb2);
    sbr2 = sbr1; sbr1 = pin_br;
    sbb2 = sbb1; sbb1 = pin_bb;
  endtask

  task automatic compare_all();
    logic [7:0] eb;
    for (int i = 0; i < 3; i++) begin
      eb = 8'((1 << nlev[i]) - 1);
      if (offer[i] >= 0) eb[offer[i]] = 1'b0;
      check_eq($sformatf("u%0d bgout", i), 32'(o_bg[i]), 32'(eb));
      check_eq($sformatf("u%0d bclr", i), 32'(o_clr[i]), 32'(!clr[i]));
      check_eq($sformatf("u%0d grant_active", i), 32'(o_act[i]),
               32'(offer[i] >= 0 || own[i]));
      check_eq($sformatf("u%0d grant_level", i), 32'(o_lvl[i]), 32'(owner[i]));
      check_eq($sformatf("u%0d timeout_pulse", i), 32'(o_to[i]), 32'(pulse[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(int phase);
    int br_rate, bb_rate;
    case (phase)
      0:       begin br_rate = 10; bb_rate = 6;  end
      1:       begin br_rate = 15; bb_rate = 60; end
      3:       begin br_rate = 3;  bb_rate = 8;  end
      default: begin br_rate = 40; bb_rate = 5;  end
    endcase
    for (int b = 0; b < 5; b++) begin
      if (phase == 2 && br[b] && $urandom_range(0, 1) == 0) br[b] = 1'b0;
      else if ($urandom_range(0, br_rate - 1) == 0) br[b] = ~br[b];
    end
    if ($urandom_range(0, bb_rate - 1) == 0) bbsy = ~bbsy;
    reset = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    reset = 1'b1;
    br    = '1;
    bbsy  = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      compare_all();
      drive(cyc / 1000);
      if (reset) model_reset();
      else       model_step(br, bbsy);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
